proc_run_controller: RTL and testbench

//   Synthesizable run controller for the single-cycle processor. Sequences processor reset, runs the program

---
 rtl/proc_run_controller.sv | 115 +++++++++++
 tb/tb_proc_run_controller.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/proc_run_controller.sv
// Run controller for the single-cycle processor: resets it, runs it to halt/timeout, then streams a DMEM window.
// Optional RUN_CTRL_PRE_DUMP_EN: also stream the window once before the run (PRE_DUMP state).
module proc_run_controller #(
    parameter int unsigned DUMP_BASE    = 8192,
    parameter int unsigned DUMP_LEN     = 100,
    parameter int unsigned RESET_CYCLES = 1,
    parameter int unsigned TIMEOUT      = 1000000,
    parameter logic [31:0] HALT_INSTR   = 32'h0000000C
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [0:31] inst_from_mem,
    input  logic        inst_valid,
    output logic        proc_reset,
    output logic        dump_active,
    output logic [0:31] dump_addr,
    input  logic [0:31] data_from_mem,
    output logic        dump_valid,
    output logic [0:7]  dump_data,
    input  logic        dump_ready,
    output logic        done,
    output logic        timed_out,
    output logic [0:31] cycle_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRE_DUMP,
        S_RST,
        S_RUN,
        S_DUMP,
        S_DONE
    } state_t;

    localparam logic [31:0] LAST_ADDR = 32'(DUMP_BASE + DUMP_LEN - 1);

    state_t      state;
    state_t      state_next;
    logic [31:0] rst_cnt;
    logic [31:0] count_inc;
    logic        halt;
    logic        hit_timeout;
    logic        accept;
    logic        last_byte;

    always_comb begin
        halt        = !inst_valid || (inst_from_mem == HALT_INSTR);
        count_inc   = (cycle_count == '1) ? cycle_count : cycle_count + 32'd1;
        hit_timeout = (TIMEOUT != 0) && (count_inc == 32'(TIMEOUT));
        accept      = dump_valid && dump_ready;
        last_byte   = (dump_addr == LAST_ADDR);
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
`ifdef RUN_CTRL_PRE_DUMP_EN
                    state_next = S_PRE_DUMP;
`else
                    state_next = S_RST;
`endif
                end
            end
            S_PRE_DUMP: if (accept && last_byte) state_next = S_RST;
            S_RST:      if (rst_cnt == 32'(RESET_CYCLES - 1)) state_next = S_RUN;
            S_RUN:      if (halt || hit_timeout) state_next = S_DUMP;
            S_DUMP:     if (accept && last_byte) state_next = S_DONE;
            default:    state_next = S_IDLE;
        endcase
    end

    // Outputs decode straight from state so an asynchronous reset takes effect immediately.
    always_comb begin
        proc_reset  = (state != S_RUN);
        dump_active = (state == S_DUMP) || (state == S_PRE_DUMP);
        dump_valid  = dump_active;
        dump_data   = dump_active ? data_from_mem[24:31] : '0;
        done        = (state == S_DONE);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            rst_cnt     <= '0;
            cycle_count <= '0;
            timed_out   <= 1'b0;
            dump_addr   <= 32'(DUMP_BASE);
        end else begin
            state <= state_next;
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        cycle_count <= '0;
                        timed_out   <= 1'b0;
                        rst_cnt     <= '0;
                    end
                end
                S_RST: rst_cnt <= rst_cnt + 32'd1;
                S_RUN: begin
                    cycle_count <= count_inc;
                    if (!halt && hit_timeout) timed_out <= 1'b1;
                end
                // Address rewinds after the last byte so every dump pass starts at the base.
                S_DUMP, S_PRE_DUMP: begin
                    if (accept) dump_addr <= last_byte ? 32'(DUMP_BASE) : dump_addr + 32'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_proc_run_controller.sv
// Self-checking bench for proc_run_controller: vector table of runs plus random runs and a mid-dump reset.
module tb_proc_run_controller;

    localparam int unsigned DUMP_BASE = 8192;
    localparam int unsigned DUMP_LEN  = 100;
    localparam int unsigned TIMEOUT   = 50;
    localparam logic [31:0] HALT      = 32'h0000000C;
`ifdef RUN_CTRL_PRE_DUMP_EN
    localparam int NDUMP = 2;
`else
    localparam int NDUMP = 1;
`endif

    logic        clock = 0;
    logic        reset = 1;
    logic        start = 0;
    logic [0:31] inst_from_mem;
    logic        inst_valid;
    logic        proc_reset;
    logic        dump_active;
    logic [0:31] dump_addr;
    logic [0:31] data_from_mem;
    logic        dump_valid;
    logic [0:7]  dump_data;
    logic        dump_ready = 0;
    logic        done;
    logic        timed_out;
    logic [0:31] cycle_count;

    proc_run_controller #(
        .DUMP_BASE(DUMP_BASE),
        .DUMP_LEN(DUMP_LEN),
        .RESET_CYCLES(1),
        .TIMEOUT(TIMEOUT),
        .HALT_INSTR(HALT)
    ) dut (
        .clock(clock), .reset(reset), .start(start),
        .inst_from_mem(inst_from_mem), .inst_valid(inst_valid),
        .proc_reset(proc_reset), .dump_active(dump_active), .dump_addr(dump_addr),
        .data_from_mem(data_from_mem), .dump_valid(dump_valid), .dump_data(dump_data),
        .dump_ready(dump_ready), .done(done), .timed_out(timed_out), .cycle_count(cycle_count)
    );

    always #5 clock = ~clock;

    logic [7:0]  mem [65536];
    logic [23:0] noise;
    logic [31:0] words [64];
    int          run_idx = 0;
    int          halt_at = 0;
    bit          halt_invalid = 0;
    int          passed = 0;
    int          total = 0;

    assign data_from_mem = {noise, mem[dump_addr[16:31]]};

    // Instruction fetch model: position in the program advances once per processor-running cycle.
    always @(posedge clock)
        if (start && proc_reset && !dump_active) run_idx <= 0;
        else if (!proc_reset) run_idx <= run_idx + 1;

    always_comb begin
        inst_from_mem = words[run_idx % 64];
        inst_valid    = 1'b1;
        if (halt_at != 0 && run_idx == halt_at - 1) begin
            if (halt_invalid) inst_valid = 1'b0;
            else inst_from_mem = HALT;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Reference: a run stops at the halt cycle if it comes no later than the timeout, else at the timeout.
    function automatic void model(input int h, output int cnt, output bit to);
        if (h != 0 && (TIMEOUT == 0 || h <= int'(TIMEOUT))) begin
            cnt = h; to = 0;
        end else begin
            cnt = TIMEOUT; to = 1;
        end
    endfunction

    function automatic bit ready_for(input int rmode, input int cyc);
        bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        case (rmode)
            0:       return 1'b1;
            1:       return pat[cyc % 4];
            default: return 1'($urandom_range(0, 1));
        endcase
    endfunction

    task automatic run_one(input int h, input bit inv, input int rmode, input bit poke,
                           input int exp_cnt, input bit exp_to);
        int run_cyc = 0, nacc = 0, cyc = 0, last_acc = -100;
        bit prev_stall = 0;
        logic [31:0] paddr = '0;
        logic [7:0]  pdata = '0;
        logic [15:0] ea;
        halt_at = h;
        halt_invalid = inv;
        @(negedge clock); start = 1;
        @(negedge clock); start = 0;
        chk("clr_done", 32'(done), 0);
        chk("clr_cycle_count", cycle_count, 0);
        chk("clr_timed_out", 32'(timed_out), 0);
        while (!done && cyc < 3000) begin
            dump_ready = ready_for(rmode, cyc);
            if (!proc_reset) run_cyc++;
            start = poke && !proc_reset && run_cyc == 2;
            if (dump_active) chk("dump_proc_reset", 32'(proc_reset), 1);
            if (dump_valid) begin
                if (prev_stall) begin
                    chk("stall_addr", dump_addr, paddr);
                    chk("stall_data", 32'(dump_data), 32'(pdata));
                end
                if (dump_ready) begin
                    ea = 16'(DUMP_BASE + nacc % DUMP_LEN);
                    chk("dump_addr", dump_addr, 32'(DUMP_BASE + nacc % DUMP_LEN));
                    chk("dump_data", 32'(dump_data), 32'(mem[ea]));
                    nacc++;
                    last_acc = cyc;
                end
                prev_stall = !dump_ready;
                paddr = dump_addr;
                pdata = dump_data;
            end else begin
                prev_stall = 0;
            end
            @(negedge clock);
            cyc++;
        end
        start = 0;
        chk("done", 32'(done), 1);
        chk("done_latency", 32'(cyc - last_acc), 1);
        chk("bytes", 32'(nacc), 32'(NDUMP * DUMP_LEN));
        chk("cycle_count", cycle_count, 32'(exp_cnt));
        chk("run_cycles", 32'(run_cyc), 32'(exp_cnt));
        chk("timed_out", 32'(timed_out), 32'(exp_to));
        chk("done_proc_reset", 32'(proc_reset), 1);
        chk("done_dump_active", 32'(dump_active), 0);
        chk("done_dump_valid", 32'(dump_valid), 0);
        @(negedge clock);
        chk("hold_cycle_count", cycle_count, 32'(exp_cnt));
        chk("hold_done", 32'(done), 1);
    endtask

    task automatic reset_mid_dump();
        int cyc = 0, nacc = 0;
        halt_at = 2;
        halt_invalid = 0;
        @(negedge clock); start = 1;
        @(negedge clock); start = 0;
        dump_ready = 1;
        while (nacc < 5 && cyc < 500) begin
            if (dump_valid) nacc++;
            @(negedge clock);
            cyc++;
        end
        chk("pre_reset_in_dump", 32'(dump_valid), 1);
        reset = 1;
        #1;
        chk("rst_proc_reset", 32'(proc_reset), 1);
        chk("rst_dump_valid", 32'(dump_valid), 0);
        chk("rst_dump_active", 32'(dump_active), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_cycle_count", cycle_count, 0);
        chk("rst_dump_addr", dump_addr, 32'(DUMP_BASE));
        @(negedge clock); reset = 0;
        repeat (5) @(negedge clock);
        chk("idle_proc_reset", 32'(proc_reset), 1);
        chk("idle_dump_active", 32'(dump_active), 0);
        chk("idle_done", 32'(done), 0);
    endtask

    typedef struct {
        int halt_at;
        bit inv;
        int rmode;
        bit poke;
        int exp_cnt;
        bit exp_to;
    } vec_t;

    initial begin
        vec_t vecs [8];
        int   cnt;
        bit   to;
        int   h;
        vecs[0] = '{4,  0, 0, 0, 4,  0};
        vecs[1] = '{0,  0, 1, 0, 50, 1};
        vecs[2] = '{1,  1, 0, 0, 1,  0};
        vecs[3] = '{50, 0, 2, 0, 50, 0};
        vecs[4] = '{51, 0, 0, 0, 50, 1};
        vecs[5] = '{3,  1, 1, 1, 3,  0};
        vecs[6] = '{1,  0, 2, 0, 1,  0};
        vecs[7] = '{49, 0, 1, 1, 49, 0};

        noise = 24'hA55A3C;
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        for (int i = 0; i < 64; i++) begin
            words[i] = $urandom;
            if (words[i] == HALT) words[i] = 32'h00000001;
        end

        @(negedge clock);
        chk("reset_proc_reset", 32'(proc_reset), 1);
        chk("reset_dump_active", 32'(dump_active), 0);
        chk("reset_dump_addr", dump_addr, 32'(DUMP_BASE));
        chk("reset_dump_valid", 32'(dump_valid), 0);
        chk("reset_dump_data", 32'(dump_data), 0);
        chk("reset_done", 32'(done), 0);
        chk("reset_timed_out", 32'(timed_out), 0);
        chk("reset_cycle_count", cycle_count, 0);
        reset = 0;
        repeat (3) @(negedge clock);
        chk("idle_wait_start", 32'(proc_reset), 1);

        for (int i = 0; i < 8; i++)
            run_one(vecs[i].halt_at, vecs[i].inv, vecs[i].rmode, vecs[i].poke,
                    vecs[i].exp_cnt, vecs[i].exp_to);

        reset_mid_dump();

        for (int i = 0; i < 6; i++) begin
            h = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, 70));
            model(h, cnt, to);
            run_one(h, 1'($urandom_range(0, 1)), 2, 1'($urandom_range(0, 1)), cnt, to);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
